// File: rtl/id_seg_reg_param_pkg.sv
// Shared constants for the IF->ID register: bubble instruction, default widths,
// and the stage action decode shared by the top and its counters.
package id_seg_reg_param_pkg;

   localparam int XLEN_DEF     = 32;
   localparam int IMEM_AW_DEF  = 12;
   localparam int FLAG_W_DEF   = 2;
   localparam int BP_IDX_W_DEF = 3;

   // addi x0,x0,0
   localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

   typedef enum logic [1:0] {
      ACT_HOLD  = 2'd0,
      ACT_LOAD  = 2'd1,
      ACT_FLUSH = 2'd2
   } stage_act_e;

   // A flush only counts when the stage advances.
   function automatic stage_act_e stage_act(input logic en, input logic clear);
      stage_act_e a;
      a = ACT_HOLD;
      if (en) a = clear ? ACT_FLUSH : ACT_LOAD;
      return a;
   endfunction

endpackage

// File: rtl/id_seg_reg_param_imem.sv
// imem_dp_sync: true dual-port synchronous RAM, read-first on both ports.
// Ports: clk; A = read-only fetch (addr_a -> rd_a); B = debug (addr_b, wd_b, we_b -> rd_b).
module imem_dp_sync
   import id_seg_reg_param_pkg::*;
#(
   parameter int DW = XLEN_DEF,
   parameter int AW = IMEM_AW_DEF
) (
   input  logic            clk,
   input  logic [AW-1:0]   addr_a,
   output logic [DW-1:0]   rd_a,
   input  logic [AW-1:0]   addr_b,
   input  logic [DW-1:0]   wd_b,
   input  logic [DW/8-1:0] we_b,
   output logic [DW-1:0]   rd_b
);

   localparam int NB = DW / 8;

   logic [DW-1:0] mem [0:2**AW-1];
   logic [DW-1:0] rd_a_q;
   logic [DW-1:0] rd_b_q;

   // Reads sample the array before this edge's write lands (read-first).
   always_ff @(posedge clk) begin
      rd_a_q <= mem[addr_a];
      rd_b_q <= mem[addr_b];
      for (int i = 0; i < NB; i++) begin
         if (we_b[i]) mem[addr_b][i*8 +: 8] <= wd_b[i*8 +: 8];
      end
   end

   assign rd_a = rd_a_q;
   assign rd_b = rd_b_q;

endmodule

// File: rtl/id_seg_reg_param.sv
// IF->ID pipeline register with integrated instruction RAM; holds InstrD across stalls,
// inserts a NOP on flush. Inputs: clk, rst_n (sync, active-low), en, clear, PCF,
// BranchFlagsF, BranchIndexF, DbgA/DbgWD/DbgWE. Outputs: PCD, InstrD, ValidD,
// BranchFlagsD, BranchIndexD, DbgRD. Define IDSEG_PERF_CNT_EN for StallCnt/FlushCnt.
module id_seg_reg_param
   import id_seg_reg_param_pkg::*;
#(
   parameter int XLEN     = XLEN_DEF,
   parameter int IMEM_AW  = IMEM_AW_DEF,
   parameter int FLAG_W   = FLAG_W_DEF,
   parameter int BP_IDX_W = BP_IDX_W_DEF,
   parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(NOP_INSTR_DEF)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic                clear,
   input  logic [XLEN-1:0]     PCF,
   input  logic [FLAG_W-1:0]   BranchFlagsF,
   input  logic [BP_IDX_W-1:0] BranchIndexF,
   output logic [XLEN-1:0]     PCD,
   output logic [XLEN-1:0]     InstrD,
   output logic                ValidD,
   output logic [FLAG_W-1:0]   BranchFlagsD,
   output logic [BP_IDX_W-1:0] BranchIndexD,
   input  logic [XLEN-1:0]     DbgA,
   input  logic [XLEN-1:0]     DbgWD,
   input  logic [XLEN/8-1:0]   DbgWE,
   output logic [XLEN-1:0]     DbgRD
`ifdef IDSEG_PERF_CNT_EN
   ,
   output logic [31:0]         StallCnt,
   output logic [31:0]         FlushCnt
`endif
);

   logic [XLEN-1:0]     pcd_q, pcd_d;
   logic                valid_q, valid_d;
   logic [FLAG_W-1:0]   flags_q, flags_d;
   logic [BP_IDX_W-1:0] idx_q, idx_d;
   logic                clr_q, clr_d;
   logic                hold_v_q, hold_v_d;
   logic [XLEN-1:0]     hold_r_q, hold_r_d;
   logic [XLEN-1:0]     ram_q;
   logic [XLEN-1:0]     instr_o;
   stage_act_e          act;

   // Only word-address bits reach the RAM; the rest alias.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{PCF[XLEN-1:IMEM_AW+2], PCF[1:0],
                               DbgA[XLEN-1:IMEM_AW+2], DbgA[1:0]};

   imem_dp_sync #(
      .DW (XLEN),
      .AW (IMEM_AW)
   ) u_imem (
      .clk    (clk),
      .addr_a (PCF[IMEM_AW+1:2]),
      .rd_a   (ram_q),
      .addr_b (DbgA[IMEM_AW+1:2]),
      .wd_b   (DbgWD),
      .we_b   (DbgWE),
      .rd_b   (DbgRD)
   );

   // RAM keeps reading during a stall, so the held word masks it.
   assign instr_o = hold_v_q ? hold_r_q : (clr_q ? NOP_INSTR : ram_q);

   always_comb begin
      act      = stage_act(en, clear);
      pcd_d    = pcd_q;
      valid_d  = valid_q;
      flags_d  = flags_q;
      idx_d    = idx_q;
      clr_d    = clr_q;
      hold_v_d = hold_v_q;
      hold_r_d = hold_r_q;
      unique case (act)
         ACT_LOAD: begin
            pcd_d    = PCF;
            valid_d  = 1'b1;
            flags_d  = BranchFlagsF;
            idx_d    = BranchIndexF;
            clr_d    = 1'b0;
            hold_v_d = 1'b0;
         end
         ACT_FLUSH: begin
            pcd_d    = '0;
            valid_d  = 1'b0;
            flags_d  = '0;
            idx_d    = '0;
            clr_d    = 1'b1;
            hold_v_d = 1'b0;
         end
         default: begin
            // Capture the visible word once, on the first stalled edge.
            if (!hold_v_q) begin
               hold_r_d = instr_o;
               hold_v_d = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pcd_q    <= '0;
         valid_q  <= 1'b0;
         flags_q  <= '0;
         idx_q    <= '0;
         clr_q    <= 1'b1;
         hold_v_q <= 1'b0;
         hold_r_q <= '0;
      end else begin
         pcd_q    <= pcd_d;
         valid_q  <= valid_d;
         flags_q  <= flags_d;
         idx_q    <= idx_d;
         clr_q    <= clr_d;
         hold_v_q <= hold_v_d;
         hold_r_q <= hold_r_d;
      end
   end

   assign PCD          = pcd_q;
   assign InstrD       = instr_o;
   assign ValidD       = valid_q;
   assign BranchFlagsD = flags_q;
   assign BranchIndexD = idx_q;

`ifdef IDSEG_PERF_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] flush_cnt_q, flush_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      unique case (act)
         ACT_HOLD: begin
            if (stall_cnt_q != 32'hFFFF_FFFF)
               stall_cnt_d = stall_cnt_q + 32'd1;
         end
         ACT_FLUSH: begin
            if (flush_cnt_q != 32'hFFFF_FFFF)
               flush_cnt_d = flush_cnt_q + 32'd1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign StallCnt = stall_cnt_q;
   assign FlushCnt = flush_cnt_q;
`endif

endmodule
